// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SEND  = 2'b01,
    DRAIN = 2'b10
  } sched_state_t;

  localparam int TIMEOUT_MULT = 32;

  function automatic int clkcount(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  localparam int TIMEOUT_DEF = TIMEOUT_MULT * clkcount(1000000, 9600);

endpackage

// File: rtl/uart_rr_arb.sv
// Round-robin priority pick: first request at or above ptr, wrapping.
module uart_rr_arb
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int off = 0; off < N; off++) begin
      j = (int'(ptr) + off) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between N_REQ producers, round-robin,
// holding newd/data until donetx and guarding each frame with a watchdog.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int CLK_FREQ    = 1000000,
  parameter int BAUD_RATE   = 9600,
  parameter int TIMEOUT_CYC = TIMEOUT_MULT * clkcount(CLK_FREQ, BAUD_RATE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         req_done,
  output logic                     tx_newd,
  output logic [7:0]               tx_data,
  input  logic                     donetx,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  sched_state_t   state;
  logic [IW-1:0]  ptr;
  logic [WW-1:0]  wd;
  logic           done_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic [IW-1:0]    nxt_ptr;
  logic             wd_hit;
  logic             done_rise;

  uart_rr_arb #(.N(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign nxt_ptr   = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);
  assign wd_hit    = (wd == WW'(TIMEOUT_CYC - 1));
  assign done_rise = donetx && !done_q;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      wd          <= '0;
      done_q      <= 1'b0;
      tx_newd     <= 1'b0;
      tx_data     <= '0;
      req_ready   <= '0;
      req_done    <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      req_ready <= '0;
      req_done  <= '0;
      done_q    <= donetx;
      if (err_clr)
        timeout_err <= 1'b0;
      // Completion wins over a watchdog expiry landing on the same edge.
      unique case (state)
        IDLE: begin
          if (arb_any && !donetx) begin
            tx_data   <= req_data[{arb_idx, 3'b000} +: 8];
            req_ready <= arb_gnt;
            grant_id  <= arb_idx;
            tx_newd   <= 1'b1;
            wd        <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (done_rise) begin
            tx_newd            <= 1'b0;
            req_done[grant_id] <= 1'b1;
            ptr                <= nxt_ptr;
            wd                 <= wd + WW'(1);
            state              <= DRAIN;
          end else if (wd_hit) begin
            tx_newd     <= 1'b0;
            timeout_err <= 1'b1;
            ptr         <= nxt_ptr;
            state       <= IDLE;
          end else begin
            wd <= wd + WW'(1);
          end
        end
        DRAIN: begin
          if (!donetx) begin
            state <= IDLE;
          end else if (wd_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd <= wd + WW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched; the bench plays the transmitter's donetx.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [3:0]  req_done;
  logic        tx_newd;
  logic [7:0]  tx_data;
  logic        donetx = 1'b0;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  uart_tx_sched #(
    .N_REQ(4), .CLK_FREQ(1000000), .BAUD_RATE(9600), .TIMEOUT_CYC(50)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done), .tx_newd(tx_newd),
    .tx_data(tx_data), .donetx(donetx), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic finish_frame(input logic [3:0] exp_done);
    donetx = 1'b1;
    tick();
    chk("done_pulse", req_done, exp_done);
    chk("done_newd_low", tx_newd, 0);
    tick();
    chk("drain_no_repeat", req_done, 0);
    chk("drain_busy", busy, 1);
    donetx = 1'b0;
    tick();
    chk("back_idle", busy, 0);
  endtask

  logic [7:0] rr_bytes [5];
  int         rr_ids [5];

  initial begin
    rr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    rr_ids   = '{0, 1, 2, 3, 0};

    #2 rst = 1'b0;
    tick(2);
    chk("rst_newd", tx_newd, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_done", req_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_err", timeout_err, 0);
    rst = 1'b1;
    tick();

    // single request from 2, valid dropped during SEND
    req_data  = 32'h44_A5_22_11;
    req_valid = 4'b0100;
    tick();
    chk("r2_ready", req_ready, 4'b0100);
    chk("r2_newd", tx_newd, 1);
    chk("r2_data", tx_data, 8'hA5);
    chk("r2_gid", grant_id, 2);
    req_valid = 4'b0000;
    req_data  = '0;
    tick(3);
    chk("r2_ready_pulse", req_ready, 0);
    chk("r2_newd_held", tx_newd, 1);
    chk("r2_data_held", tx_data, 8'hA5);
    finish_frame(4'b0100);

    // reset mid-SEND, pointer returns to 0
    req_data  = 32'h44_33_22_11;
    req_valid = 4'b1000;
    tick();
    chk("r3_gid", grant_id, 3);
    tick();
    rst = 1'b0;
    #1;
    chk("arst_newd", tx_newd, 0);
    chk("arst_busy", busy, 0);
    chk("arst_gid", grant_id, 0);
    chk("arst_data", tx_data, 0);
    req_valid = 4'b1010;
    #2 rst = 1'b1;
    tick();
    chk("rearb_gid", grant_id, 1);
    chk("rearb_data", tx_data, 8'h22);
    req_valid = 4'b0000;
    finish_frame(4'b0010);

    // round robin with everyone requesting
    rst = 1'b0;
    #2 rst = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_gid", grant_id, rr_ids[i]);
      chk("rr_data", tx_data, rr_bytes[i]);
      chk("rr_ready", req_ready, 4'b0001 << rr_ids[i]);
      finish_frame(4'b0001 << rr_ids[i]);
    end
    req_valid = 4'b0000;

    // stale donetx blocks grant
    donetx    = 1'b1;
    req_valid = 4'b0010;
    tick(3);
    chk("stale_busy", busy, 0);
    chk("stale_ready", req_ready, 0);
    donetx = 1'b0;
    tick();
    chk("unstale_ready", req_ready, 4'b0010);
    chk("unstale_newd", tx_newd, 1);
    req_valid = 4'b0000;
    finish_frame(4'b0010);

    // watchdog: r2 times out, r3 served next
    req_valid = 4'b0100;
    tick();
    chk("wd_gid", grant_id, 2);
    req_valid = 4'b1100;
    tick(49);
    chk("wd_newd_49", tx_newd, 1);
    chk("wd_err_49", timeout_err, 0);
    tick();
    chk("wd_newd_50", tx_newd, 0);
    chk("wd_err_50", timeout_err, 1);
    chk("wd_no_done", req_done, 0);
    chk("wd_idle", busy, 0);
    tick();
    chk("wd_next_gid", grant_id, 3);
    chk("wd_err_kept", timeout_err, 1);
    req_valid = 4'b0000;

    // clear coinciding with a second timeout keeps the flag
    tick(49);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_vs_to", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", timeout_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
